// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0 prefixes into {extended, release, code}
// events and queues them in a first-word-fall-through FIFO. Optional shift tracking: PS2_SHIFT_TRACK_EN.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       rx_enable,
    output logic       evt_valid,
    output logic [9:0] evt_data,
    input  logic       evt_ready,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       shift_held
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GOT_E0   = 2'd1;
    localparam logic [1:0] ST_GOT_F0   = 2'd2;
    localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

    localparam logic [7:0] BYTE_EXT     = 8'hE0;
    localparam logic [7:0] BYTE_BREAK   = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT  = 8'h12;
    localparam logic [7:0] CODE_RSHIFT  = 8'h59;

    // Keyboard housekeeping bytes (error, BAT ok, echo, ack, resend, overrun)
    localparam int          NUM_IGN   = 6;
    localparam logic [47:0] IGN_CODES = {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    logic [1:0]        state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic [9:0]        mem_reg [FIFO_DEPTH];

    logic [NUM_IGN-1:0] ign_hit;
    logic               byte_ignored;
    logic               byte_is_ext;
    logic               byte_is_break;
    logic               evt_push;
    logic               evt_ext;
    logic               evt_rel;
    logic [9:0]         evt_word;
    logic               fifo_full;
    logic               fifo_empty;
    logic               do_pop;
    logic               do_push;
    logic               do_drop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IGN; gi++) begin : g_ign
            assign ign_hit[gi] = (byte_data == IGN_CODES[gi*8 +: 8]);
        end
    endgenerate

    assign byte_ignored  = |ign_hit;
    assign byte_is_ext   = (byte_data == BYTE_EXT);
    assign byte_is_break = (byte_data == BYTE_BREAK);
    assign evt_push      = byte_valid && !byte_ignored && !byte_is_ext && !byte_is_break;

    assign evt_ext  = (state_reg == ST_GOT_E0) || (state_reg == ST_GOT_E0F0);
    assign evt_rel  = (state_reg == ST_GOT_F0) || (state_reg == ST_GOT_E0F0);
    assign evt_word = {evt_ext, evt_rel, byte_data};

    assign fifo_full  = (count_reg == CNT_FULL);
    assign fifo_empty = (count_reg == '0);

    // A pop frees the slot the same cycle, so a full FIFO can still accept.
    assign do_pop  = evt_ready && !fifo_empty;
    assign do_push = evt_push && (!fifo_full || do_pop);
    assign do_drop = evt_push && fifo_full && !do_pop;

    always_comb begin
        state_next = state_reg;
        if (byte_valid) begin
            if (byte_is_ext) begin
                state_next = ST_GOT_E0;
            end else if (byte_is_break) begin
                case (state_reg)
                    ST_IDLE:   state_next = ST_GOT_F0;
                    ST_GOT_E0: state_next = ST_GOT_E0F0;
                    default:   state_next = state_reg;
                endcase
            end else if (!byte_ignored) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_comb begin
        overflow_next = overflow_reg;
        if (do_drop) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage needs no reset: evt_data is only meaningful while evt_valid is high.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_reg[wr_ptr_reg] <= evt_word;
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_data  = mem_reg[rd_ptr_reg];
    assign rx_enable = !fifo_full;
    assign overflow  = overflow_reg;

`ifdef PS2_SHIFT_TRACK_EN
    logic lshift_reg, lshift_next;
    logic rshift_reg, rshift_next;

    // Tracks every decoded key event, even ones the FIFO had to drop.
    always_comb begin
        lshift_next = lshift_reg;
        rshift_next = rshift_reg;
        if (evt_push && !evt_ext) begin
            if (byte_data == CODE_LSHIFT) begin
                lshift_next = !evt_rel;
            end
            if (byte_data == CODE_RSHIFT) begin
                rshift_next = !evt_rel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lshift_reg <= 1'b0;
            rshift_reg <= 1'b0;
        end else begin
            lshift_reg <= lshift_next;
            rshift_reg <= rshift_next;
        end
    end

    assign shift_held = lshift_reg || rshift_reg;
`else
    assign shift_held = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: stimulus queues expected events,
// a negedge monitor pops and compares on every accepted handshake.
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       rx_enable;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       evt_ready;
    logic       overflow;
    logic       ovf_clr;
    logic       shift_held;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .rx_enable  (rx_enable),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .shift_held (shift_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%03h want=0x%03h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%03h", name, act);
        end
    endtask

    // Monitor: the head seen at negedge is the one consumed at the next posedge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected got=0x%03h want=none", evt_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    errors++;
                    $display("FAIL evt_data got=0x%03h want=0x%03h", evt_data, e);
                end else begin
                    $display("ok   evt_data = 0x%03h", evt_data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_evt(input logic [7:0] b, input logic [9:0] exp);
        exp_q.push_back(exp);
        send_byte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    initial begin
        logic [9:0] shift_on;
        bit drained;
`ifdef PS2_SHIFT_TRACK_EN
        shift_on = 10'd1;
`else
        shift_on = 10'd0;
`endif
        rst = 1'b1; byte_data = 8'h00; byte_valid = 1'b0;
        evt_ready = 1'b0; ovf_clr = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("rst_evt_valid", 10'(evt_valid), 10'd0);
        check("rst_rx_enable", 10'(rx_enable), 10'd1);
        check("rst_overflow", 10'(overflow), 10'd0);
        check("rst_shift_held", 10'(shift_held), 10'd0);

        evt_ready = 1'b1;
        // Plain make code, event visible one clock after the strobe
        send_evt(8'h1C, 10'h01C);
        check("latency_evt_valid", 10'(evt_valid), 10'd1);
        idle(2);

        send_byte(8'hE0);
        check("prefix_e0_no_evt", 10'(evt_valid), 10'd0);
        send_byte(8'hF0);
        check("prefix_e0f0_no_evt", 10'(evt_valid), 10'd0);
        send_evt(8'h75, 10'h375);
        idle(2);
        send_byte(8'hF0);
        send_evt(8'h1C, 10'h11C);
        idle(2);

        // Reset in mid-prefix forgets the prefix
        send_byte(8'hE0);
        send_byte(8'hF0);
        pulse_rst();
        send_evt(8'h1C, 10'h01C);
        idle(2);

        // Housekeeping bytes are invisible, also inside a prefix
        send_byte(8'hFA);
        check("ignored_fa_no_evt", 10'(evt_valid), 10'd0);
        send_byte(8'hE0);
        send_byte(8'hFA);
        send_byte(8'hF0);
        send_byte(8'hAA);
        send_evt(8'h75, 10'h375);
        idle(2);

        // Fill to full, then overflow
        evt_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send_evt(8'(i), 10'(i));
            if (i == 7) check("rx_enable_at7", 10'(rx_enable), 10'd1);
        end
        check("rx_enable_full", 10'(rx_enable), 10'd0);
        check("head_stable", evt_data, 10'h001);
        send_byte(8'h09);
        check("overflow_set", 10'(overflow), 10'd1);
        check("head_after_drop", evt_data, 10'h001);
        pulse_clr();
        check("overflow_clr", 10'(overflow), 10'd0);

        // Drop coincident with clear: set wins
        @(posedge clk); #1;
        byte_data = 8'h0B; byte_valid = 1'b1; ovf_clr = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0; ovf_clr = 1'b0;
        check("overflow_set_wins", 10'(overflow), 10'd1);
        pulse_clr();

        // Full with simultaneous push and pop
        @(posedge clk); #1;
        byte_data = 8'h0A; byte_valid = 1'b1; evt_ready = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0; evt_ready = 1'b0;
        exp_q.push_back(10'h00A);
        check("full_pushpop_rx_enable", 10'(rx_enable), 10'd0);
        check("full_pushpop_overflow", 10'(overflow), 10'd0);
        check("full_pushpop_head", evt_data, 10'h002);

        evt_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!evt_valid) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain_done", 10'(drained), 10'd1);
        check("drain_rx_enable", 10'(rx_enable), 10'd1);

        // Shift tracking; events are queued in every build
        send_evt(8'h12, 10'h012);
        check("shift_l_make", 10'(shift_held), shift_on);
        send_evt(8'h59, 10'h059);
        send_byte(8'hF0);
        send_evt(8'h12, 10'h112);
        check("shift_r_still", 10'(shift_held), shift_on);
        send_byte(8'hF0);
        send_evt(8'h59, 10'h159);
        check("shift_all_up", 10'(shift_held), 10'd0);
        send_byte(8'hE0);
        send_evt(8'h12, 10'h212);
        check("shift_ext_ignored", 10'(shift_held), 10'd0);
        idle(3);

        check("scoreboard_empty", 10'(exp_q.size()), 10'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
REQ-002 Port: clk  input  1  system clock; every flop samples on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: byte_data  input  8  received PS/2 byte from the receiver stage.
REQ-005 Port: byte_valid  input  1  one-cycle strobe; byte_data valid this cycle (driven by receiver's full_byte_received).
REQ-006 Port: rx_enable  output  1  high when FIFO not full; drives receiver's wait_for_data.
REQ-007 Port: evt_valid  output  1  FIFO non-empty; evt_data valid.
REQ-008 Port: evt_data  output  10  {extended, release, code[7:0]} at FIFO head.
REQ-009 Port: evt_ready  input  1  consumer accept; pops head when evt_valid & evt_ready.
REQ-010 Port: overflow  output  1  sticky; event dropped because FIFO full.
REQ-011 Port: ovf_clr  input  1  one-cycle clear of overflow.
REQ-012 Port: shift_held  output  1  either shift key currently pressed (see Configuration).

Function
REQ-013 Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0; advances only on cycles with byte_valid=1.
REQ-014 Byte 0xE0 from any state -> GOT_E0; partial prefix discarded, no event.
REQ-015 Byte 0xF0: IDLE->GOT_F0, GOT_E0->GOT_E0F0, GOT_F0/GOT_E0F0 hold; no event.
REQ-016 Bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF discarded in every state; FSM state unchanged.
REQ-017 Any other byte: event {extended=(state in GOT_E0,GOT_E0F0), release=(state in GOT_F0,GOT_E0F0), code=byte_data} pushed; FSM -> IDLE same edge.
REQ-018 Latency: evt_valid/evt_data reflect a pushed event on the first edge after the edge sampling the final byte (1 clock).
REQ-019 FIFO first-word-fall-through; evt_data stable while evt_valid=1 and evt_ready=0.
REQ-020 evt_ready with evt_valid=0 is ignored; no underflow, no pointer change.
REQ-021 Push when full and no pop same cycle: event dropped, overflow set next edge, FIFO contents unchanged.
REQ-022 Push and pop same cycle when full: both performed, occupancy unchanged, overflow not set.
REQ-023 Push and pop same cycle when empty: push only takes effect (evt_valid was 0).
REQ-024 Pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1; full when count==FIFO_DEPTH.
REQ-025 ovf_clr clears overflow; if an overflow drop coincides with ovf_clr, overflow ends set (set wins).
REQ-026 rx_enable = ~full, combinational from registered count.

Reset
REQ-027 rst=1 at posedge: FSM->IDLE, pointers and count->0, overflow=0, shift state=0; takes priority over all inputs including byte_valid.
REQ-028 After reset: evt_valid=0, rx_enable=1, overflow=0, shift_held=0; evt_data undefined while evt_valid=0.
REQ-029 Reset mid-sequence (e.g. after 0xE0,0xF0) discards the prefix; next plain code yields extended=0, release=0.

Configuration
REQ-030 Macro PS2_SHIFT_TRACK_EN defined: left shift (0x12) and right shift (0x59), non-extended only, tracked with one flag each, set on make, cleared on break; shift_held = OR of flags, updated on the same edge as the event push, independent of FIFO full.
REQ-031 PS2_SHIFT_TRACK_EN undefined: no shift flops, shift_held tied 0.
REQ-032 Both builds push shift events into the FIFO as ordinary events.

Verification
REQ-033 Bytes 0x1C -> one event 0x01C (ext=0, rel=0), evt_valid 1 clock after strobe.
REQ-034 Bytes 0xE0,0xF0,0x75 -> one event 0x375; 0xF0,0x1C -> 0x11C; no events for prefixes.
REQ-035 evt_ready=0, push FIFO_DEPTH+1 codes (0x01..0x09 at depth 8) -> rx_enable=0 after 8th, 9th dropped, overflow=1; drain yields 0x001..0x008 in order; ovf_clr -> overflow=0.
REQ-036 Full FIFO, code strobe with evt_ready=1 same cycle -> count stays 8, overflow stays 0, head advances.
REQ-037 Bytes 0xE0, rst pulse, 0x1C -> event 0x01C; bytes 0xFA, 0xAA interleaved -> no events.
REQ-038 With PS2_SHIFT_TRACK_EN: 0x12 -> shift_held=1; 0x59, 0xF0,0x12 -> still 1; 0xF0,0x59 -> 0; 0xE0,0x12 -> no change. Without: shift_held always 0.
